// File: rtl/hamming_dec_arbiter.sv
// Purpose: round-robin sharing of one 21-bit Hamming decoder among NCH channels, one word in flight.
// Latency: 5 cycles from channel transfer to out_valid when the decoder answers 2 cycles after its load pulse.
// Backpressure: result held in HOLD until out_ready; no channel is granted while busy; WAIT watchdog drops stuck words.
module hamming_dec_arbiter #(
    parameter int NCH     = 4,
    parameter int CW      = 21,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH*CW-1:0] ch_data,
    output logic [NCH-1:0]    ch_ready,
    output logic [CW-1:0]     dec_data,
    output logic              dec_ivalid,
    input  logic              dec_oready,
    output logic              dec_iready,
    input  logic [DW-1:0]     dec_odata,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [2:0]        out_ch,
    input  logic              out_ready,
    output logic              busy,
    output logic [7:0]        timeout_cnt
);

    localparam int CHW = $clog2(NCH);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COLLECT, HOLD} state_t;

    state_t         state;
    state_t         nextState;
    logic [CHW-1:0] lastGrant;
    logic [CHW-1:0] curCh;
    logic [CHW-1:0] grant;
    logic [CHW-1:0] idx;
    logic           anyValid;
    logic [TW-1:0]  timer;
    logic           timerDone;

    // Watchdog expiry: the last permitted WAIT cycle without a decoder answer.
    assign timerDone = (timer == TW'(TIMEOUT - 1));

    // Round-robin search starting just after the last served channel.
    always_comb begin
        grant    = '0;
        anyValid = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = CHW'((int'(lastGrant) + k) % NCH);
            if (!anyValid && ch_valid[idx]) begin
                anyValid = 1'b1;
                grant    = idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a decoder answer takes priority over the watchdog.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyValid) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT: begin
                if (dec_oready) begin
                    nextState = COLLECT;
                end else if (timerDone) begin
                    nextState = IDLE;
                end
            end
            COLLECT: nextState = HOLD;
            HOLD:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes and handshakes are pure state decodes so each is an isolated pulse.
    always_comb begin
        ch_ready   = '0;
        dec_ivalid = 1'b0;
        dec_iready = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (anyValid) ch_ready = NCH'(1) << grant;
            ISSUE:   dec_ivalid = 1'b1;
            COLLECT: dec_iready = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture the granted word, run the watchdog, latch the result, advance priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant   <= CHW'(NCH - 1);
            curCh       <= '0;
            dec_data    <= '0;
            out_data    <= '0;
            out_ch      <= '0;
            timeout_cnt <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        dec_data <= ch_data[int'(grant)*CW +: CW];
                        curCh    <= grant;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (!dec_oready) begin
                        timer <= timer + TW'(1);
                        if (timerDone) begin
                            lastGrant <= curCh;
                            if (timeout_cnt != 8'hFF) begin
                                timeout_cnt <= timeout_cnt + 8'd1;
                            end
                        end
                    end
                end
                COLLECT: begin
                    out_data <= dec_odata;
                    out_ch   <= 3'(curCh);
                end
                HOLD: if (out_ready) lastGrant <= curCh;
                default: ;
            endcase
        end
    end

endmodule
